// File: rtl/fwd_hazard_scoreboard_if.sv
// Bundle between the ID stage and the forwarding/hazard scoreboard.
//   master : ID-stage side, drives the decoded instruction and flush, observes stall/selects/count
//   slave  : scoreboard side
// Signals:
//   id_valid, id_src[NUM_SRC*REG_AW], id_dst[REG_AW], id_wr, id_is_load, flush  (ID -> scoreboard)
//   stall, ex_fwd_sel[NUM_SRC*SEL_W], stall_count[CNT_W]                        (scoreboard -> ID/EX)
interface fwd_hazard_scoreboard_if #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned SEL_W = $clog2(FWD_STAGES + 1);

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_wr;
  logic                      id_is_load;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output id_valid, id_src, id_dst, id_wr, id_is_load, flush,
    input  stall, ex_fwd_sel, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_dst, id_wr, id_is_load, flush,
    output stall, ex_fwd_sel, stall_count
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding + load-use hazard unit. Keeps a private shift-register scoreboard of in-flight
// writers (slot 0 = instruction in EX, slot j = j stages older) and produces:
//   bus.stall       combinational load-use stall for IF/ID
//   bus.ex_fwd_sel  registered per-operand select for the EX instruction (0 = regfile, k = stage k)
//   bus.stall_count saturating count of stall cycles since reset
// Ports: clk (rising edge), rst_n (async active-low), bus (fwd_hazard_scoreboard_if.slave).
module fwd_hazard_scoreboard #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  fwd_hazard_scoreboard_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(FWD_STAGES + 1);

  logic [FWD_STAGES-1:0]    slot_valid_q;
  logic [FWD_STAGES-1:0]    slot_load_q;
  logic [REG_AW-1:0]        slot_dst_q [FWD_STAGES];
  logic [NUM_SRC*SEL_W-1:0] next_sel;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_q;
  logic [NUM_SRC-1:0]       hazard;
  logic [CNT_W-1:0]         stall_count_q;
  logic                     stall;
  logic                     accept;
  logic                     new_valid;

  // Scan oldest to youngest so the youngest matching slot overwrites any older match.
  always_comb begin
    next_sel = '0;
    hazard   = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int j = int'(FWD_STAGES) - 1; j >= 0; j--) begin
        if (slot_valid_q[j] && (slot_dst_q[j] == bus.id_src[i*REG_AW +: REG_AW]) &&
            (bus.id_src[i*REG_AW +: REG_AW] != '0)) begin
          next_sel[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
          // Load data only becomes forwardable from LOAD_STAGE onwards.
          hazard[i] = slot_load_q[j] && ((j + 1) < int'(LOAD_STAGE));
        end
      end
    end
  end

  assign stall     = bus.id_valid & ~bus.flush & (|hazard);
  assign accept    = bus.id_valid & ~stall & ~bus.flush;
  assign new_valid = accept & bus.id_wr & (bus.id_dst != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q  <= '0;
      slot_load_q   <= '0;
      for (int j = 0; j < int'(FWD_STAGES); j++) slot_dst_q[j] <= '0;
      ex_fwd_sel_q  <= '0;
      stall_count_q <= '0;
    end else begin
      for (int j = 1; j < int'(FWD_STAGES); j++) begin
        slot_valid_q[j] <= slot_valid_q[j-1];
        slot_load_q[j]  <= slot_load_q[j-1];
        slot_dst_q[j]   <= slot_dst_q[j-1];
      end
      slot_valid_q[0] <= new_valid;
      slot_load_q[0]  <= bus.id_is_load;
      slot_dst_q[0]   <= bus.id_dst;
      // A stalled or flushed ID slot becomes a bubble in EX: no forwarding.
      ex_fwd_sel_q    <= accept ? next_sel : '0;
      if (stall && (stall_count_q != '1)) stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign bus.stall       = stall;
  assign bus.ex_fwd_sel  = ex_fwd_sel_q;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: two instances share one instruction stream
// (a: 2 stages, load at stage 2; b: 3 stages, load at stage 3), both with a 5-bit counter.
module tb_fwd_hazard_scoreboard;
  localparam int AW   = 5;
  localparam int NS   = 2;
  localparam int CW   = 5;
  localparam int CMAX = 31;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           id_valid, id_wr, id_is_load, flush;
  logic [NS*AW-1:0] id_src;
  logic [AW-1:0]  id_dst;

  fwd_hazard_scoreboard_if #(.REG_AW(AW), .NUM_SRC(NS), .FWD_STAGES(2), .CNT_W(CW)) bus_a ();
  fwd_hazard_scoreboard_if #(.REG_AW(AW), .NUM_SRC(NS), .FWD_STAGES(3), .CNT_W(CW)) bus_b ();

  assign bus_a.id_valid = id_valid;   assign bus_b.id_valid = id_valid;
  assign bus_a.id_src = id_src;       assign bus_b.id_src = id_src;
  assign bus_a.id_dst = id_dst;       assign bus_b.id_dst = id_dst;
  assign bus_a.id_wr = id_wr;         assign bus_b.id_wr = id_wr;
  assign bus_a.id_is_load = id_is_load; assign bus_b.id_is_load = id_is_load;
  assign bus_a.flush = flush;         assign bus_b.flush = flush;

  fwd_hazard_scoreboard #(.REG_AW(AW), .NUM_SRC(NS), .FWD_STAGES(2), .LOAD_STAGE(2),
                          .CNT_W(CW)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  fwd_hazard_scoreboard #(.REG_AW(AW), .NUM_SRC(NS), .FWD_STAGES(3), .LOAD_STAGE(3),
                          .CNT_W(CW)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic       stall_a, stall_b;
  logic [3:0] sel_a, sel_b;
  logic [CW-1:0] cnt_a, cnt_b;
  assign stall_a = bus_a.stall;       assign stall_b = bus_b.stall;
  assign sel_a = bus_a.ex_fwd_sel;    assign sel_b = bus_b.ex_fwd_sel;
  assign cnt_a = bus_a.stall_count;   assign cnt_b = bus_b.stall_count;

  int checks = 0;
  int failures = 0;

  // Model: history of writers that entered EX, age 1 = youngest.
  int depth [2] = '{2, 3};
  int lstage [2] = '{2, 3};
  bit hv [2][3];
  int hd [2][3];
  bit hl [2][3];
  bit m_stall [2];
  int m_nsel [2][2];
  int exp_sel [2][2];
  int exp_cnt [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pack(input int s0, input int s1);
    return (s1 << 2) | s0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        hv[d][k] = 0; hd[d][k] = 0; hl[d][k] = 0;
      end
      exp_sel[d][0] = 0; exp_sel[d][1] = 0; exp_cnt[d] = 0; m_stall[d] = 0;
    end
  endtask

  task automatic model_eval(input int d);
    m_stall[d] = 0;
    for (int i = 0; i < NS; i++) begin
      int src;
      int sel;
      bit haz;
      src = int'(id_src[i*AW +: AW]);
      sel = 0;
      haz = 0;
      for (int age = 1; age <= depth[d]; age++) begin
        if (sel == 0 && hv[d][age-1] && hd[d][age-1] == src && src != 0) begin
          sel = age;
          haz = hl[d][age-1] && (age < lstage[d]);
        end
      end
      m_nsel[d][i] = sel;
      if (haz && id_valid && !flush) m_stall[d] = 1;
    end
  endtask

  task automatic model_clock(input int d);
    bit take;
    take = id_valid && !m_stall[d] && !flush;
    for (int i = 0; i < NS; i++) exp_sel[d][i] = take ? m_nsel[d][i] : 0;
    if (m_stall[d] && exp_cnt[d] < CMAX) exp_cnt[d]++;
    for (int k = depth[d] - 1; k >= 1; k--) begin
      hv[d][k] = hv[d][k-1]; hd[d][k] = hd[d][k-1]; hl[d][k] = hl[d][k-1];
    end
    hv[d][0] = take && id_wr && (id_dst != 0);
    hd[d][0] = int'(id_dst);
    hl[d][0] = id_is_load;
  endtask

  // One cycle: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    model_eval(0);
    model_eval(1);
    chk("stall_a", int'(stall_a), int'(m_stall[0]));
    chk("sel_a", int'(sel_a), pack(exp_sel[0][0], exp_sel[0][1]));
    chk("count_a", int'(cnt_a), exp_cnt[0]);
    chk("stall_b", int'(stall_b), int'(m_stall[1]));
    chk("sel_b", int'(sel_b), pack(exp_sel[1][0], exp_sel[1][1]));
    chk("count_b", int'(cnt_b), exp_cnt[1]);
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1;
  endtask

  task automatic set_instr(input bit v, input bit wr, input bit ld, input int dst,
                           input int s0, input int s1, input bit fl);
    id_valid = v; id_wr = wr; id_is_load = ld; flush = fl;
    id_dst = AW'(dst);
    id_src = {AW'(s1), AW'(s0)};
  endtask

  task automatic nops(input int n);
    set_instr(0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  // Hold the instruction in ID until instance d stops stalling.
  task automatic issue(input int d, input bit wr, input bit ld, input int dst,
                       input int s0, input int s1);
    bit done;
    done = 0;
    set_instr(1, wr, ld, dst, s0, s1, 0);
    for (int n = 0; n < 8 && !done; n++) begin
      step();
      if (!m_stall[d]) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL issue_timeout actual=stalled required=accepted");
    end
  endtask

  initial begin
    model_reset();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sel_a", int'(sel_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_stall_a", int'(stall_a), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // add r3; add r4,r3,r5
    nops(3);
    issue(0, 1, 0, 3, 1, 2);
    issue(0, 1, 0, 4, 3, 5);
    chk("t1_sel_a", int'(sel_a), 1);
    chk("t1_cnt_a", int'(cnt_a), 0);

    // add r3; nop; sub r6,r3,r3
    nops(3);
    issue(0, 1, 0, 3, 1, 2);
    nops(1);
    issue(0, 1, 0, 6, 3, 3);
    chk("t2_sel_a", int'(sel_a), 10);
    chk("t2_sel_b", int'(sel_b), 10);

    // lw r7; add r8,r7,r1
    nops(3);
    issue(0, 1, 1, 7, 1, 0);
    set_instr(1, 1, 0, 8, 7, 1, 0);
    step();
    chk("t3_bubble_a", int'(sel_a), 0);
    chk("t3_cnt_a", int'(cnt_a), 1);
    step();
    chk("t3_sel_a", int'(sel_a), 2);
    chk("t3_cnt_a_hold", int'(cnt_a), 1);
    step();
    chk("t3_cnt_b", int'(cnt_b), 2);
    chk("t3_sel_b", int'(sel_b), 3);

    // add r2; add r2; or r9,r2,r0 then add r0; or r9,r0,r0
    nops(3);
    issue(0, 1, 0, 2, 1, 1);
    issue(0, 1, 0, 2, 1, 1);
    issue(0, 1, 0, 9, 2, 0);
    chk("t4_sel_a", int'(sel_a), 1);
    issue(0, 1, 0, 0, 1, 1);
    issue(0, 1, 0, 9, 0, 0);
    chk("t4_r0_a", int'(sel_a), 0);

    // lw r7 then a flushed consumer
    nops(3);
    issue(0, 1, 1, 7, 1, 0);
    set_instr(1, 1, 0, 8, 7, 1, 1);
    step();
    chk("t5_cnt_a", int'(cnt_a), 1);
    chk("t5_cnt_b", int'(cnt_b), 2);
    chk("t5_sel_a", int'(sel_a), 0);

    // random traffic over a small register window to force frequent matches
    nops(3);
    for (int n = 0; n < 1500; n++) begin
      set_instr($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 9) == 0);
      step();
    end

    // reset asserted while a stall is pending
    nops(3);
    issue(0, 1, 1, 7, 1, 0);
    set_instr(1, 1, 0, 8, 7, 1, 0);
    @(negedge clk);
    chk("t6_stall_before", int'(stall_a), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_stall_a", int'(stall_a), 0);
    chk("t6_sel_a", int'(sel_a), 0);
    chk("t6_cnt_a", int'(cnt_a), 0);
    chk("t6_cnt_b", int'(cnt_b), 0);
    model_reset();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 40 load-use pairs: more stalls than the 5-bit counter can hold
    for (int n = 0; n < 40; n++) begin
      issue(0, 1, 1, 7, 1, 0);
      issue(0, 1, 0, 8, 7, 1);
    end
    nops(1);
    chk("sat_cnt_a", int'(cnt_a), 31);
    chk("sat_cnt_b", int'(cnt_b), 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
